// File: rtl/microc_stack.sv
// microc_stack: single-cycle microcontroller datapath with a hardware
// return-address stack. The datapath has a PC, a 16-bit instruction fetch
// port, a register file, an 8-operation ALU and a zero flag. Two sticky
// flags report a call made while the stack is full and a return made while
// it is empty. An external control unit drives every control input each cycle.
module microc_stack #(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int NREG   = 16,
  parameter int SDEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    instr,
  output logic [PCW-1:0] pc,
  input  logic           s_inc,
  input  logic           s_inm,
  input  logic           we3,
  input  logic           wez,
  input  logic [2:0]     Op,
  input  logic           s_call,
  input  logic           s_ret,
  output logic [5:0]     Opcode,
  output logic           z,
  output logic           stk_ovf,
  output logic           stk_unf
);

  // The stack pointer counts occupied entries, so it must hold 0..SDEPTH.
  localparam int SPW = $clog2(SDEPTH + 1);

  logic [3:0]            ra1, ra2, wa3;
  logic [7:0]            imm;
  logic [PCW-1:0]        target, pc_inc, stk_top;
  logic [DW-1:0]         rf [NREG];
  logic signed [DW-1:0]  rd1, rd2, alu_y;
  logic [DW-1:0]         wd3;
  logic [PCW-1:0]        stk [SDEPTH];
  logic [SPW-1:0]        sp;
  logic                  stk_empty, stk_full;

  // ALU: all arithmetic is modulo 2^DW, so carries and borrows are dropped.
  function automatic logic signed [DW-1:0] alu_fn(input logic [2:0] op,
                                                  input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return ~a;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return -a;
      default: return -b;
    endcase
  endfunction

  assign ra1    = instr[11:8];
  assign ra2    = instr[7:4];
  assign wa3    = instr[3:0];
  assign imm    = instr[11:4];
  assign target = instr[PCW-1:0];
  assign Opcode = instr[15:10];
  assign pc_inc = pc + PCW'(1);

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SPW'(SDEPTH));

  // Combinational register reads; R0 and indices at or beyond NREG read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (ra1 == 4'(i)) rd1 = rf[i];
      if (ra2 == 4'(i)) rd2 = rf[i];
    end
  end

  // Top-of-stack entry, i.e. the most recently pushed return address.
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < SDEPTH; i++) begin
      if (sp == SPW'(i + 1)) stk_top = stk[i];
    end
  end

  assign alu_y = alu_fn(Op, rd1, rd2);
  assign wd3   = s_inm ? DW'(imm) : alu_y;

  // Register file write port; R0 and out-of-range indices never get written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we3) begin
      for (int i = 1; i < NREG; i++) begin
        if (wa3 == 4'(i)) rf[i] <= wd3;
      end
    end
  end

  // Zero flag follows the ALU result only when wez is set, regardless of we3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) z <= 1'b0;
    else if (wez) z <= (alu_y == '0);
  end

  // Next-PC selection and the return stack. A return outranks a call, a call
  // outranks increment/jump. A call on a full stack still jumps, but its
  // return address is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      sp      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      for (int i = 0; i < SDEPTH; i++) stk[i] <= '0;
    end else if (s_ret) begin
      if (!stk_empty) begin
        pc <= stk_top;
        sp <= sp - SPW'(1);
      end else begin
        stk_unf <= 1'b1;
        pc      <= pc_inc;
      end
    end else if (s_call) begin
      pc <= target;
      if (!stk_full) begin
        for (int i = 0; i < SDEPTH; i++) begin
          if (sp == SPW'(i)) stk[i] <= pc_inc;
        end
        sp <= sp + SPW'(1);
      end else begin
        stk_ovf <= 1'b1;
      end
    end else if (s_inc) begin
      pc <= pc_inc;
    end else begin
      pc <= target;
    end
  end

endmodule

// File: doc/microc_stack.md
Name: microc_stack

Overview:
- Parametrised successor to the single-cycle microcontroller datapath: PC, 16-bit instruction fetch port, register file, 8-operation ALU, zero flag.
- Adds a hardware return-address stack (call/return), generic data width and PC width, and sticky stack error flags.
- The external control unit (or a testbench) drives it cycle by cycle and reads back Opcode and z.
- The instruction memory is external, so benches can supply arbitrary programs.

Parameters:
- DW, 8, data/register width (≥8); the 8-bit immediate is zero-extended to DW.
- PCW, 10, PC width (1..10); the jump target is instr[PCW-1:0].
- NREG, 16, number of registers (≤16); register indices are instr fields, 4 bits each.
- SDEPTH, 4, return-stack depth in entries (≥1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr  in  16  instruction word at address pc (combinational memory)
- pc  out  PCW  current program counter, used as instruction address
- s_inc  in  1  1: next PC = pc+1; 0: next PC = jump target
- s_inm  in  1  1: register write data = immediate; 0: ALU result
- we3  in  1  register file write enable
- wez  in  1  zero-flag write enable
- Op  in  3  ALU operation
- s_call  in  1  push pc+1, jump to target
- s_ret  in  1  pop return address into PC
- Opcode  out  6  instr[15:10]
- z  out  1  registered zero flag
- stk_ovf  out  1  sticky: call attempted with stack full
- stk_unf  out  1  sticky: return attempted with stack empty

Behaviour:
- Reset (asynchronous, any time, including mid-program) clears to 0: pc, z, all registers, stack pointer, stack entries, stk_ovf, stk_unf.
- Instruction fields:
  - RA1 = instr[11:8], RA2 = instr[7:4], WA3 = instr[3:0].
  - imm = instr[11:4].
  - target = instr[PCW-1:0].
- Register file:
  - RD1 and RD2 are combinational reads.
  - Writes are synchronous on the rising edge when we3=1.
  - R0 always reads 0; writes to R0 are ignored.
  - An index ≥ NREG reads 0 and ignores writes.
- Write data: s_inm ? zero-extended imm : ALU result.
- ALU on A=RD1, B=RD2, DW-bit result, carries discarded (modulo 2^DW):
  - 000 A
  - 001 ~A
  - 010 A+B
  - 011 A−B
  - 100 A&B
  - 101 A|B
  - 110 −A
  - 111 −B
- Zero flag: on a rising edge with wez=1, z <= (ALU result == 0); otherwise z holds. z depends only on wez, not on we3.
- Next-PC priority, evaluated every rising edge:
  1. s_ret:
     - stack non-empty: pop; pc <= top entry.
     - stack empty: stk_unf <= 1; pc <= pc+1.
  2. else s_call:
     - stack not full: push pc+1; pc <= target.
     - stack full: stk_ovf <= 1; pc <= target; stack unchanged (return address lost).
  3. else s_inc=1: pc <= pc+1.
  4. else: pc <= target.
- pc+1 wraps modulo 2^PCW; a pushed return address wraps the same way.
- Stack is LIFO, depth SDEPTH, one operation per cycle.
- s_call=s_ret=1 in the same cycle: return only; the call is ignored.
- stk_ovf and stk_unf stay at 1 until reset.
- Register writes and z updates occur in the same cycle as a call or return when enabled; they are independent of PC selection.
- Latency:
  - Opcode is combinational from instr.
  - pc, registers, z and the stack update one edge after their controls are sampled.

Test Plan:
- Reset then load immediates: instr=0x1052 with s_inm=1, we3=1 → R2=0x05. Then instr=0x1033 → R3=0x03. pc increments 0→1→2.
- ALU and zero flag: Op=011, RA1=2, RA2=2, WA3=4, we3=1, wez=1 → R4=0, z=1. Then Op=010, RA1=2, RA2=3 → result 0x08, z=0.
- Jump: s_inc=0, instr[9:0]=0x3F5 with PCW=10 → pc=0x3F5. From pc=0x3FF with s_inc=1 → pc=0x000 (wrap).
- Call/return: at pc=0x010, s_call with target 0x100 → pc=0x100. Next cycle s_ret → pc=0x011. Flags remain 0.
- Stack limits (SDEPTH=4): 5 nested calls → stk_ovf=1, 5th return address lost; 4 returns restore the correct order. A 5th return → stk_unf=1, pc=pc+1.
- Simultaneous events and reset: s_call=s_ret=1 with the stack holding 0x020 → pc=0x020, stack empty. Asserting reset mid-cycle → pc, z, flags and registers clear immediately, without waiting for a clock edge.
